// File: rtl/rns_pkg.sv
// Shared constants and per-stage payload types for the binary-to-RNS forward converter.
// Moduli set {2^N+1, 2^N, 2^N-1} with N = RNS_N.
// Stage payload structs are sized by RNS_N, so the top's N parameter must equal RNS_N.
package rns_pkg;

    localparam int RNS_N = 35;
    localparam int W_X1  = RNS_N + 1;
    localparam int W_X   = 3 * RNS_N;

    localparam logic [W_X1-1:0]  MOD_P1 = {1'b1, {(RNS_N-1){1'b0}}, 1'b1};
    localparam logic [RNS_N-1:0] MOD_M1 = {RNS_N{1'b1}};

    // S0: raw chunks X = b2*2^(2N) + b1*2^N + b0, plus the range flag.
    typedef struct packed {
        logic             ovf;
        logic [RNS_N-1:0] b2;
        logic [RNS_N-1:0] b1;
        logic [RNS_N-1:0] b0;
    } s0_t;

    // S1: partial sums; q may still be the all-ones alias of zero.
    typedef struct packed {
        logic             ovf;
        logic [RNS_N-1:0] x2;
        logic [RNS_N:0]   p;
        logic [RNS_N-1:0] q;
        logic [RNS_N-1:0] b1;
        logic [RNS_N-1:0] b2;
    } s1_t;

    // S2: canonical residues as presented at the outputs.
    typedef struct packed {
        logic             ovf;
        logic [RNS_N:0]   x1;
        logic [RNS_N-1:0] x2;
        logic [RNS_N-1:0] x3;
    } s2_t;

endpackage

// File: rtl/add_mod_2n_m1.sv
// Purpose: W-bit adder modulo 2^W-1 using end-around carry.
// Latency: combinational. Backpressure: none (pure datapath).
// Ports: a_i, b_i operands (all-ones accepted as zero); sum_o result.
// CANON=1 maps the all-ones alias of zero to 0; CANON=0 leaves it as produced.
module add_mod_2n_m1 #(
    parameter int W     = 35,
    parameter bit CANON = 1'b1
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    logic [W:0]   raw;
    logic [W-1:0] eac;

    // Folding the carry back in cannot overflow again: the largest raw sum
    // 2^(W+1)-2 folds to exactly 2^W-1.
    assign raw   = {1'b0, a_i} + {1'b0, b_i};
    assign eac   = raw[W-1:0] + {{(W-1){1'b0}}, raw[W]};
    assign sum_o = (CANON && (&eac)) ? '0 : eac;

endmodule

// File: rtl/rns_forward_converter_pipe.sv
// Purpose: binary (3N bits) to RNS residues {mod 2^N+1, mod 2^N, mod 2^N-1} converter.
// Latency: 3 cycles (S0 -> S1 -> S2), throughput 1/cycle, bubbles collapse.
// Backpressure: full valid/ready; in_ready is combinational from out_ready, no skid buffer.
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_x; out_valid/out_ready,
//        out_x1 (N+1), out_x2 (N), out_x3 (N), out_ovf.
// Optional: RNS_FWD_RANGE_CHECK_EN builds the X >= M flag on out_ovf; otherwise out_ovf = 0.
module rns_forward_converter_pipe
    import rns_pkg::*;
#(
    parameter int N = RNS_N
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [3*N-1:0] in_x,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N:0]     out_x1,
    output logic [N-1:0]   out_x2,
    output logic [N-1:0]   out_x3,
    output logic           out_ovf
);

    logic v0_q, v1_q, v2_q;
    s0_t  s0_q, s0_d;
    s1_t  s1_q, s1_d;
    s2_t  s2_q, s2_d;

    logic ld0, ld1, ld2, adv2;

    // Stage handshakes: each stage loads when its source is valid and it is
    // either empty or emptying this cycle.
    assign adv2     = v2_q & out_ready;
    assign ld2      = v1_q & (~v2_q | adv2);
    assign ld1      = v0_q & (~v1_q | ld2);
    assign in_ready = ~v0_q | ld1;
    assign ld0      = in_valid & in_ready;

    // S0 input: chunk the operand.
    always_comb begin
        s0_d    = '0;
        s0_d.b0 = in_x[N-1:0];
        s0_d.b1 = in_x[2*N-1:N];
        s0_d.b2 = in_x[3*N-1:2*N];
`ifdef RNS_FWD_RANGE_CHECK_EN
        // M = 2^(3N) - 2^N, so X >= M exactly when the upper 2N bits are all ones.
        s0_d.ovf = &in_x[3*N-1:N];
`else
        s0_d.ovf = 1'b0;
`endif
    end

    // S1: 2^N == 1 mod 2^N-1, so start the x3 sum with b0 + b1.
    logic [N-1:0] q_sum;

    add_mod_2n_m1 #(.W(N), .CANON(1'b0)) u_add_q (
        .a_i   (s0_q.b0),
        .b_i   (s0_q.b1),
        .sum_o (q_sum)
    );

    always_comb begin
        s1_d     = '0;
        s1_d.x2  = s0_q.b0;
        s1_d.p   = {1'b0, s0_q.b0} + {1'b0, s0_q.b2};
        s1_d.q   = q_sum;
        s1_d.b1  = s0_q.b1;
        s1_d.b2  = s0_q.b2;
        s1_d.ovf = s0_q.ovf;
    end

    // S2: 2^N == -1 mod 2^N+1, so x1 = b0 - b1 + b2 with one signed correction.
    logic [N+1:0] d;
    logic [N:0]   d_add, d_sub;
    logic [N-1:0] x3_sum;

    assign d     = {1'b0, s1_q.p} - {2'b00, s1_q.b1};
    // Corrected values fit in N+1 bits, so the wrap in the upper bit is harmless.
    assign d_add = d[N:0] + MOD_P1;
    assign d_sub = d[N:0] - MOD_P1;

    add_mod_2n_m1 #(.W(N), .CANON(1'b1)) u_add_x3 (
        .a_i   (s1_q.q),
        .b_i   (s1_q.b2),
        .sum_o (x3_sum)
    );

    always_comb begin
        s2_d     = '0;
        s2_d.x2  = s1_q.x2;
        s2_d.x3  = x3_sum;
        s2_d.ovf = s1_q.ovf;
        if (d[N+1]) begin
            s2_d.x1 = d_add;
        end else if (d[N:0] >= MOD_P1) begin
            s2_d.x1 = d_sub;
        end else begin
            s2_d.x1 = d[N:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v0_q <= 1'b0;
            v1_q <= 1'b0;
            v2_q <= 1'b0;
            s0_q <= '0;
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            v0_q <= ld0 | (v0_q & ~ld1);
            v1_q <= ld1 | (v1_q & ~ld2);
            v2_q <= ld2 | (v2_q & ~adv2);
            if (ld0) s0_q <= s0_d;
            if (ld1) s1_q <= s1_d;
            if (ld2) s2_q <= s2_d;
        end
    end

    assign out_valid = v2_q;
    assign out_x1    = s2_q.x1;
    assign out_x2    = s2_q.x2;
    assign out_x3    = s2_q.x3;
    assign out_ovf   = s2_q.ovf;

endmodule

// File: tb/tb_rns_forward_converter_pipe.sv
// Self-checking bench for rns_forward_converter_pipe (N=35): directed values,
// streaming latency/throughput, backpressure, mid-stream reset and CRT round trip.
// Honours RNS_FWD_RANGE_CHECK_EN for the expected out_ovf value.
module tb_rns_forward_converter_pipe;

`ifdef RNS_FWD_RANGE_CHECK_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    localparam logic [127:0] TWO_N = 128'h1 << 35;
    localparam logic [127:0] P1    = TWO_N + 128'h1;
    localparam logic [127:0] M1    = TWO_N - 128'h1;
    localparam logic [127:0] MM    = P1 * TWO_N * M1;
    localparam logic [127:0] XMASK = (128'h1 << 105) - 128'h1;

    typedef logic [106:0] res_t;   // {x1[35:0], x2[34:0], x3[34:0], ovf}

    typedef struct {
        logic [127:0] x;
        res_t         exp;
        bit           tab;
        bit           rt;
    } sb_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [104:0]  in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [35:0]   out_x1;
    logic [34:0]   out_x2;
    logic [34:0]   out_x3;
    logic          out_ovf;

    rns_forward_converter_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_x      (in_x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_x1    (out_x1),
        .out_x2    (out_x2),
        .out_x3    (out_x3),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_chk = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, n_pop = 0, first_push = -1, first_pop = -1, last_pop = -1;
    sb_t sbq[$];

    bit           drv_rst = 1'b1, drv_vld = 1'b0, drv_rdy = 1'b0;
    bit           drv_tab_en = 1'b0, drv_rt = 1'b0, acc = 1'b0;
    logic [104:0] drv_x = '0;
    res_t         drv_tab = '0;

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_ovf(logic [127:0] x);
        return OVF_EN && (x >= MM);
    endfunction

    // Reference: plain modular arithmetic on the whole operand.
    function automatic res_t model(logic [127:0] x);
        logic [127:0] r1, r2, r3;
        r1 = x % P1;
        r2 = x % TWO_N;
        r3 = x % M1;
        return {r1[35:0], r2[34:0], r3[34:0], exp_ovf(x)};
    endfunction

    // Reverse conversion: X = x2 + 2^N*Y, Y recovered from its residues
    // mod 2^N+1 and 2^N-1 (inverse of 2^N is -1 and 1 there; inverse of
    // 2^N-1 mod 2^N+1 is 2^(N-1)).
    function automatic logic [127:0] recon(logic [35:0] r1, logic [34:0] r2, logic [34:0] r3);
        logic [127:0] a1, a2, a3, y1, y3, t, k;
        a1 = 128'(r1);
        a2 = 128'(r2);
        a3 = 128'(r3);
        y1 = (a2 % P1 + P1 - (a1 % P1)) % P1;
        y3 = (a3 % M1 + M1 - (a2 % M1)) % M1;
        t  = (y1 + P1 - y3) % P1;
        k  = (t * (TWO_N >> 1)) % P1;
        return a2 + TWO_N * (y3 + M1 * k);
    endfunction

    function automatic logic [127:0] rand_x();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r & XMASK;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 time unit later,
    // and account for the handshakes that the next rising edge completes.
    task automatic step();
        sb_t  e;
        res_t obs;
        @(negedge clk);
        rst       = drv_rst;
        in_valid  = drv_vld;
        in_x      = drv_x;
        out_ready = drv_rdy;
        #1;
        acc = 1'b0;
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_pop++;
                if (first_pop < 0) first_pop = cyc;
                last_pop = cyc;
                chk("out_expected", 128'(sbq.size() != 0), 128'h1);
                if (sbq.size() != 0) begin
                    e   = sbq.pop_front();
                    obs = {out_x1, out_x2, out_x3, out_ovf};
                    if (e.rt)
                        chk("roundtrip", recon(out_x1, out_x2, out_x3), e.x);
                    else if (e.tab)
                        chk("directed", 128'(obs), 128'(e.exp));
                    else
                        chk("stream", 128'(obs), 128'(e.exp));
                end
            end
            if (in_valid && in_ready) begin
                acc = 1'b1;
                if (first_push < 0) first_push = cyc;
                e.x   = 128'(in_x);
                e.exp = drv_tab_en ? drv_tab : model(128'(in_x));
                e.tab = drv_tab_en;
                e.rt  = drv_rt;
                sbq.push_back(e);
            end
        end
        cyc++;
    endtask

    task automatic send(logic [127:0] x, bit tab_en, res_t tab, bit rt, bit rnd_rdy);
        drv_vld    = 1'b1;
        drv_x      = x[104:0];
        drv_tab_en = tab_en;
        drv_tab    = tab;
        drv_rt     = rt;
        for (int i = 0; i < 64; i++) begin
            if (rnd_rdy) drv_rdy = ($urandom_range(0, 3) != 0);
            step();
            if (acc) break;
        end
        if (!acc) chk("send_timeout", 128'(acc), 128'h1);
        drv_vld    = 1'b0;
        drv_tab_en = 1'b0;
        drv_rt     = 1'b0;
    endtask

    task automatic dir(logic [127:0] x, logic [35:0] e1, logic [34:0] e2, logic [34:0] e3, bit ovf_if_en);
        send(x, 1'b1, {e1, e2, e3, OVF_EN & ovf_if_en}, 1'b0, 1'b0);
    endtask

    task automatic drain();
        drv_vld = 1'b0;
        drv_rdy = 1'b1;
        for (int i = 0; i < 32 && (sbq.size() != 0 || out_valid); i++) step();
        chk("drain_empty", 128'(sbq.size()), 128'h0);
    endtask

    initial begin
        int   n_acc, unstable;
        bit   snap_vld;
        res_t snap;

        // Reset and first cycle after release.
        drv_rst = 1'b1;
        step();
        step();
        drv_rst = 1'b0;
        drv_rdy = 1'b1;
        step();
        chk("rst_out_valid", 128'(out_valid), 128'h0);
        chk("rst_outputs", 128'({out_x1, out_x2, out_x3, out_ovf}), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'h1);

        // Directed values and extremes.
        dir(128'h0, 36'h0, 35'h0, 35'h0, 1'b0);
        dir(128'h1, 36'h1, 35'h1, 35'h1, 1'b0);
        dir(TWO_N, 36'h8_0000_0000, 35'h0, 35'h1, 1'b0);
        dir(TWO_N << 35, 36'h1, 35'h0, 35'h1, 1'b0);
        dir(TWO_N - 128'h1, 36'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 35'h0, 1'b0);
        dir(MM - 128'h1, 36'h8_0000_0000, 35'h7_FFFF_FFFF, 35'h7_FFFF_FFFE, 1'b0);
        dir(MM, 36'h0, 35'h0, 35'h0, 1'b1);
        dir(XMASK, 36'h7_FFFF_FFFF, 35'h7_FFFF_FFFF, 35'h0, 1'b1);
        drain();

        // Back-to-back streaming: latency and throughput.
        first_push = -1;
        first_pop  = -1;
        n_pop      = 0;
        for (int i = 0; i < 100; i++) send(rand_x(), 1'b0, '0, 1'b0, 1'b0);
        drain();
        chk("latency", 128'(first_pop - first_push), 128'd3);
        chk("stream_count", 128'(n_pop), 128'd100);
        chk("throughput", 128'(last_pop - first_pop), 128'd99);

        // Backpressure: stall the consumer for 10 cycles while offering input.
        drv_rdy  = 1'b0;
        drv_vld  = 1'b1;
        drv_x    = rand_x();
        n_acc    = 0;
        unstable = 0;
        snap_vld = 1'b0;
        snap     = '0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (snap_vld) begin
                if ({out_x1, out_x2, out_x3, out_ovf} !== snap || out_valid !== 1'b1) unstable++;
            end else if (out_valid) begin
                snap     = {out_x1, out_x2, out_x3, out_ovf};
                snap_vld = 1'b1;
            end
            if (acc) begin
                n_acc++;
                drv_x = rand_x();
            end
        end
        chk("bp_accepted", 128'(n_acc), 128'd3);
        chk("bp_in_ready_low", 128'(in_ready), 128'h0);
        chk("bp_out_valid", 128'(snap_vld), 128'h1);
        chk("bp_stable", 128'(unstable), 128'h0);
        drv_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (acc) drv_x = rand_x();
        end
        drain();

        // Reset with three operands in flight.
        drv_rdy = 1'b0;
        drv_vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv_x = rand_x();
            step();
        end
        chk("pre_rst_inflight", 128'(sbq.size()), 128'd3);
        drv_rst = 1'b1;
        step();
        sbq.delete();
        drv_rst = 1'b0;
        drv_vld = 1'b0;
        drv_rdy = 1'b1;
        step();
        chk("midrst_out_valid", 128'(out_valid), 128'h0);
        chk("midrst_outputs", 128'({out_x1, out_x2, out_x3, out_ovf}), 128'h0);
        chk("midrst_in_ready", 128'(in_ready), 128'h1);
        for (int i = 0; i < 6; i++) step();

        // Round trip through a reverse conversion, random bubbles and stalls.
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                drv_vld = 1'b0;
                drv_rdy = ($urandom_range(0, 1) != 0);
                step();
            end
            send(rand_x() % MM, 1'b0, '0, 1'b1, 1'b1);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rns_forward_converter_pipe.md
Name: rns_forward_converter_pipe

Overview:
- Pipelined binary-to-RNS forward converter for the moduli set {2^N+1, 2^N, 2^N-1}; default N=35.
- Sits directly upstream of the reverse converter. Its residue outputs match the reverse converter's x1 (N+1 bits), x2 (N bits) and x3 (N bits) inputs exactly.
- Accepts one 3N-bit binary operand per cycle over a valid/ready handshake. Emits canonical residues after a fixed 3-stage pipeline, with full backpressure.

Parameters:
- N, 35, base exponent; all port widths derive from it.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_x holds a valid operand.
- in_ready  out  1  the block accepts in_x in this cycle.
- in_x  in  3N  binary operand X, unsigned.
- out_valid  out  1  out_x1/x2/x3 are valid.
- out_ready  in  1  the consumer accepts the outputs.
- out_x1  out  N+1  X mod (2^N+1), in the range 0..2^N.
- out_x2  out  N  X mod 2^N.
- out_x3  out  N  X mod (2^N-1), in the range 0..2^N-2.
- out_ovf  out  1  X >= M, where M=(2^N+1)*2^N*(2^N-1); present only with the optional feature.

Behaviour:
- Chunking: X = B2*2^(2N) + B1*2^N + B0, with each Bi N bits wide.
- Pipeline structure:
  - Three register stages S0, S1, S2, each holding a valid bit plus a payload.
  - A transfer into a stage occurs when the source is valid and (the stage is empty, or the stage is transferring out in the same cycle).
  - in_ready = !S0.v | S0 advancing. It is combinational from out_ready through the stage chain; no skid buffer.
  - Latency: 3 cycles from input handshake to out_valid with no stalls. Throughput is 1 per cycle. Bubbles collapse.
- S0: registers B0, B1, B2.
- S1 computes:
  - x2 = B0.
  - p = B0 + B2, N+1 bits, unsigned.
  - q = B0 + B1 mod (2^N-1), using end-around carry.
  - B1 and B2 are forwarded.
- S2 computes:
  - d = p - B1, signed, N+2 bits.
  - x1 = d + (2^N+1) if d<0; d - (2^N+1) if d >= 2^N+1; otherwise d. One correction always suffices, since d lies in [-(2^N-1), 2^(N+1)-2].
  - x3 = q + B2 with end-around carry; an all-ones result is forced to 0 (canonical form).
- Outputs come straight from S2 registers; there is no combinational logic after S2.
- Output stability: while out_valid=1 and out_ready=0, all out_* values and out_valid hold unchanged.
- Reset:
  - All stage valid bits clear, so out_valid=0.
  - out_x1, out_x2, out_x3 and out_ovf reset to 0.
  - in_ready=1 in the first cycle after reset is released.
  - Reset mid-operation drops every in-flight operand; nothing partial is emitted.
- Simultaneous events: accepting an input while S2 drains in the same cycle is legal and loses no data.

Optional Feature:
- Macro: RNS_FWD_RANGE_CHECK_EN.
- Defined:
  - S0 computes the compare X >= M.
  - The flag travels alongside its operand through the pipeline and drives out_ovf, aligned with the residues.
  - Residues are still computed from X as if the compare were absent.
- Undefined: no compare logic is built and out_ovf is tied to 0. The port stays, so the interface is identical in both builds.

Decomposition:
- Package rns_pkg holds:
  - localparams RNS_N, W_X1 = N+1, W_X = 3N.
  - Modulus constants MOD_P1 = 2^N+1 and MOD_M1 = 2^N-1.
  - A stage-payload struct typedef per stage.
- Sub-module add_mod_2n_m1: N-bit end-around-carry adder with a canonicalising output flag. It is instantiated twice, once in S1 and once in S2.

Test Plan (N=35):
- Value checks:
  - X=0 -> (x1,x2,x3)=(0,0,0).
  - X=1 -> (1,1,1).
  - X=2^35 -> (2^35, 0, 1).
  - X=2^70 -> (1, 0, 1).
- Canonicalisation and extremes:
  - X=2^35-1 -> x3=0, x2=2^35-1, x1=2^35-1.
  - X=M-1 -> (2^35, 2^35-1, 2^35-2), out_ovf=0.
  - X=2^105-1 -> out_ovf=1 when the macro is defined, 0 when it is not.
- Streaming: 100 back-to-back random X with out_ready=1.
  - The first out_valid appears 3 cycles after the first handshake.
  - One result per cycle after that.
  - Each result matches a software mod model.
- Backpressure: hold out_ready=0 for 10 cycles while streaming.
  - in_ready falls once S0–S2 are full (3 operands held).
  - Outputs stay stable.
  - No loss or duplication after release.
  - The order of results is preserved.
- Reset mid-stream: assert rst for 1 cycle with 3 operands in flight.
  - out_valid=0 and outputs are 0 on the next cycle.
  - in_ready=1.
  - None of the dropped operands ever appears at the output.
- Round trip: feed the outputs into the reverse converter for 1000 random X < M -> reconstructed value equals X.
